// File: rtl/tile_collision_probe.sv
// Background collision probe: walks 8 points around the sprite box through level
// memory and publishes left/right/up/down blocked flags once the whole sweep is done.
//
// state  | meaning
// IDLE   | waiting for enable; latches sprite box on start
// ADDR   | registers memory address of the current probe
// WAIT   | lets level memory catch up (MEM_LATENCY cycles)
// SAMPLE | folds the tile (or forced boundary) into its direction
// DONE   | flags valid, done held until enable drops
module tile_collision_probe #(
  parameter int          TILE_SHIFT    = 3,
  parameter int          LEVEL_W_SHIFT = 11,
  parameter int          LEVEL_H_TILES = 15,
  parameter int          MEM_LATENCY   = 1,
  parameter logic [3:0]  EMPTY_TILE    = 4'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] x_location,
  input  logic [6:0]  y_location,
  input  logic [4:0]  width,
  input  logic [4:0]  height,
  input  logic [3:0]  memory_input,
  output logic [14:0] memory_address,
  output logic        left,
  output logic        right,
  output logic        up,
  output logic        down,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_SAMPLE, S_DONE} state_t;

  localparam int          WAIT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam logic [31:0] COL_LIMIT = 32'(1) << LEVEL_W_SHIFT;
  localparam logic [31:0] COL_MASK  = COL_LIMIT - 32'd1;
  localparam logic [7:0]  ROW_LIMIT = 8'(LEVEL_H_TILES);

  state_t              state_q, state_d;
  logic [31:0]         x0_q, x1_q;
  logic [7:0]          y0_q, y1_q;
  logic [2:0]          idx_q;
  logic [3:0]          acc_q, acc_d;
  logic [3:0]          flags_q;
  logic [14:0]         addr_q;
  logic [WAIT_W-1:0]   wait_q;

  logic [4:0]          w_eff, h_eff;
  logic [31:0]         px, col;
  logic [7:0]          py, row;
  logic [1:0]          dir;
  logic [14:0]         probe_addr;
  logic                solid;

  assign w_eff = (width  == 5'd0) ? 5'd1 : width;
  assign h_eff = (height == 5'd0) ? 5'd1 : height;

  // dir: 0 left, 1 right, 2 up, 3 down; even idx uses the near corner
  always_comb begin
    px = x0_q;
    py = y0_q;
    case (idx_q)
      3'd0: begin px = x0_q - 32'd1; py = y0_q;         end
      3'd1: begin px = x0_q - 32'd1; py = y1_q;         end
      3'd2: begin px = x1_q + 32'd1; py = y0_q;         end
      3'd3: begin px = x1_q + 32'd1; py = y1_q;         end
      3'd4: begin px = x0_q;         py = y0_q - 8'd1;  end
      3'd5: begin px = x1_q;         py = y0_q - 8'd1;  end
      3'd6: begin px = x0_q;         py = y1_q + 8'd1;  end
      default: begin px = x1_q;      py = y1_q + 8'd1;  end
    endcase
    col        = px >> TILE_SHIFT;
    row        = py >> TILE_SHIFT;
    dir        = idx_q[2:1];
    probe_addr = 15'(({24'd0, row} << LEVEL_W_SHIFT) | (col & COL_MASK));
  end

  // Off-level probes never trust memory: walls on the sides and top, a pit below.
  always_comb begin
    if (dir == 2'd0 && x0_q == 32'd0)      solid = 1'b1;
    else if (col >= COL_LIMIT)             solid = 1'b1;
    else if (dir == 2'd2 && y0_q == 8'd0)  solid = 1'b1;
    else if (row >= ROW_LIMIT)             solid = 1'b0;
    else                                   solid = (memory_input != EMPTY_TILE);
    acc_d      = acc_q;
    acc_d[dir] = acc_q[dir] | solid;
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (enable) state_d = S_ADDR;
      S_ADDR:   state_d = enable ? S_WAIT : S_IDLE;
      S_WAIT:   if (!enable) state_d = S_IDLE;
                else if (wait_q == '0) state_d = S_SAMPLE;
      S_SAMPLE: if (!enable) state_d = S_IDLE;
                else state_d = (idx_q == 3'd7) ? S_DONE : S_ADDR;
      S_DONE:   if (!enable) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done = (state_q == S_DONE);
    busy = (state_q == S_ADDR) || (state_q == S_WAIT) || (state_q == S_SAMPLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      flags_q <= '0;
      addr_q  <= '0;
      wait_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (enable) begin
          x0_q  <= x_location;
          x1_q  <= x_location + 32'(w_eff) - 32'd1;
          y0_q  <= {1'b0, y_location};
          y1_q  <= {1'b0, y_location} + 8'(h_eff) - 8'd1;
          idx_q <= '0;
          acc_q <= '0;
        end
        S_ADDR: if (enable) begin
          addr_q <= probe_addr;
          wait_q <= WAIT_W'(MEM_LATENCY - 1);
        end
        S_WAIT: if (wait_q != '0) wait_q <= wait_q - 1'b1;
        S_SAMPLE: if (enable) begin
          acc_q <= acc_d;
          if (idx_q == 3'd7) flags_q <= acc_d;
          else               idx_q   <= idx_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign memory_address = addr_q;
  assign left  = flags_q[0];
  assign right = flags_q[1];
  assign up    = flags_q[2];
  assign down  = flags_q[3];

endmodule
